// File: rtl/mux_8_1_pkg.sv
// Shared constants for the 8:1 word multiplexer: select width, lane count
// and the default lane-enable mask.
package mux_8_1_pkg;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned LANES = 8;
    localparam logic [LANES-1:0] DEFAULT_LANE_MASK = 8'hFF;
endpackage

// File: rtl/mux_8_1_sel.sv
// Combinational 8:1 word decode; lanes disabled in LANE_MASK read as zero.
module mux_8_1_sel
    import mux_8_1_pkg::*;
#(
    parameter int unsigned       WORD      = 16,
    parameter logic [LANES-1:0]  LANE_MASK = DEFAULT_LANE_MASK
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic [WORD-1:0]  in_0_i,
    input  logic [WORD-1:0]  in_1_i,
    input  logic [WORD-1:0]  in_2_i,
    input  logic [WORD-1:0]  in_3_i,
    input  logic [WORD-1:0]  in_4_i,
    input  logic [WORD-1:0]  in_5_i,
    input  logic [WORD-1:0]  in_6_i,
    input  logic [WORD-1:0]  in_7_i,
    output logic [WORD-1:0]  out_o
);

    always_comb begin
        out_o = '0;
        if (LANE_MASK[sel_i]) begin
            case (sel_i)
                3'd0:    out_o = in_0_i;
                3'd1:    out_o = in_1_i;
                3'd2:    out_o = in_2_i;
                3'd3:    out_o = in_3_i;
                3'd4:    out_o = in_4_i;
                3'd5:    out_o = in_5_i;
                3'd6:    out_o = in_6_i;
                default: out_o = in_7_i;
            endcase
        end
    end

endmodule

// File: rtl/mux_8_1.sv
// 8:1 word multiplexer with registered copy of the selected word and select.
// Define MUX_8_1_SEL_ERR_EN to add the registered sel_err flag (masked lane loaded).
module mux_8_1
    import mux_8_1_pkg::*;
#(
    parameter int unsigned       WORD      = 16,
    parameter logic [LANES-1:0]  LANE_MASK = DEFAULT_LANE_MASK
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEL_W-1:0] select,
    input  logic [WORD-1:0]  IN_0,
    input  logic [WORD-1:0]  IN_1,
    input  logic [WORD-1:0]  IN_2,
    input  logic [WORD-1:0]  IN_3,
    input  logic [WORD-1:0]  IN_4,
    input  logic [WORD-1:0]  IN_5,
    input  logic [WORD-1:0]  IN_6,
    input  logic [WORD-1:0]  IN_7,
    input  logic             load,
    output logic [WORD-1:0]  OUT,
    output logic [WORD-1:0]  OUT_Q,
    output logic [SEL_W-1:0] sel_q
`ifdef MUX_8_1_SEL_ERR_EN
    ,
    output logic             sel_err
`endif
);

    logic [WORD-1:0]  out_d;
    // Power-up value keeps OUT_Q defined before the first reset or load edge.
    logic [WORD-1:0]  out_q     = '0;
    logic [SEL_W-1:0] sel_cap_q = '0;

    mux_8_1_sel #(
        .WORD      (WORD),
        .LANE_MASK (LANE_MASK)
    ) u_sel (
        .sel_i  (select),
        .in_0_i (IN_0),
        .in_1_i (IN_1),
        .in_2_i (IN_2),
        .in_3_i (IN_3),
        .in_4_i (IN_4),
        .in_5_i (IN_5),
        .in_6_i (IN_6),
        .in_7_i (IN_7),
        .out_o  (out_d)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q     <= '0;
            sel_cap_q <= '0;
        end else if (load) begin
            out_q     <= out_d;
            sel_cap_q <= select;
        end
    end

    assign OUT   = out_d;
    assign OUT_Q = out_q;
    assign sel_q = sel_cap_q;

`ifdef MUX_8_1_SEL_ERR_EN
    logic sel_err_d;
    logic sel_err_q = 1'b0;

    assign sel_err_d = ~LANE_MASK[select];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
        end else if (load) begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_8_1.sv
// Self-checking bench for mux_8_1: directed scenarios plus randomized traffic
// against a lane-rule reference model, on a full-mask and a 8'h7F-mask instance.
module tb_mux_8_1;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b1;
    logic         load    = 1'b0;
    logic [2:0]   select  = 3'd0;
    logic [W-1:0] in_w [8];

    wire [W-1:0] out_a, outq_a, out_b, outq_b;
    wire [2:0]   selq_a, selq_b;
`ifdef MUX_8_1_SEL_ERR_EN
    wire         err_a, err_b;
`endif

    int total = 0;
    int bad   = 0;

    mux_8_1 #(.WORD(W)) dut_a (
        .clk(clk), .reset_n(reset_n), .select(select),
        .IN_0(in_w[0]), .IN_1(in_w[1]), .IN_2(in_w[2]), .IN_3(in_w[3]),
        .IN_4(in_w[4]), .IN_5(in_w[5]), .IN_6(in_w[6]), .IN_7(in_w[7]),
        .load(load), .OUT(out_a), .OUT_Q(outq_a), .sel_q(selq_a)
`ifdef MUX_8_1_SEL_ERR_EN
        , .sel_err(err_a)
`endif
    );

    mux_8_1 #(.WORD(W), .LANE_MASK(8'h7F)) dut_b (
        .clk(clk), .reset_n(reset_n), .select(select),
        .IN_0(in_w[0]), .IN_1(in_w[1]), .IN_2(in_w[2]), .IN_3(in_w[3]),
        .IN_4(in_w[4]), .IN_5(in_w[5]), .IN_6(in_w[6]), .IN_7(in_w[7]),
        .load(load), .OUT(out_b), .OUT_Q(outq_b), .sel_q(selq_b)
`ifdef MUX_8_1_SEL_ERR_EN
        , .sel_err(err_b)
`endif
    );

    // Reference rule: an enabled lane passes its word, a masked lane reads zero.
    function automatic logic [W-1:0] pick(input logic [7:0] mask, input logic [2:0] s);
        return mask[s] ? in_w[s] : '0;
    endfunction

    task automatic set_ramp();
        for (int k = 0; k < 8; k++) in_w[k] = 16'h1000 + W'(k);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (outq_a !== 16'h0000) begin bad++; $display("FAIL powerup_outq got=%h want=0000", outq_a); end
        total++; if (selq_a !== 3'd0) begin bad++; $display("FAIL powerup_selq got=%0d want=0", selq_a); end
        set_ramp();
        reset_n = 1'b0; load = 1'b1; select = 3'd7;
        #1;
        total++; if (out_a !== 16'h1007) begin bad++; $display("FAIL reset_out_comb got=%h want=1007", out_a); end
        tick();
        total++; if (outq_a !== 16'h0000) begin bad++; $display("FAIL reset_outq got=%h want=0000", outq_a); end
        total++; if (selq_a !== 3'd0) begin bad++; $display("FAIL reset_selq got=%0d want=0", selq_a); end
        total++; if (out_a !== 16'h1007) begin bad++; $display("FAIL reset_out_kept got=%h want=1007", out_a); end
`ifdef MUX_8_1_SEL_ERR_EN
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_b); end
`endif
        reset_n = 1'b1; load = 1'b0;
    endtask

    task automatic test_sweep();
        set_ramp();
        for (int s = 0; s < 8; s++) begin
            select = 3'(s);
            #1;
            total++;
            if (out_a !== 16'h1000 + W'(s)) begin
                bad++; $display("FAIL sweep_out sel=%0d got=%h want=%h", s, out_a, 16'h1000 + W'(s));
            end
        end
    endtask

    task automatic test_load_hold();
        select = 3'd5; load = 1'b1;
        tick();
        total++; if (outq_a !== 16'h1005) begin bad++; $display("FAIL load_outq got=%h want=1005", outq_a); end
        total++; if (selq_a !== 3'd5) begin bad++; $display("FAIL load_selq got=%0d want=5", selq_a); end
        load = 1'b0; select = 3'd2;
        #1;
        total++; if (out_a !== 16'h1002) begin bad++; $display("FAIL hold_out got=%h want=1002", out_a); end
        total++; if (outq_a !== 16'h1005) begin bad++; $display("FAIL hold_outq_pre got=%h want=1005", outq_a); end
        tick();
        total++; if (outq_a !== 16'h1005) begin bad++; $display("FAIL hold_outq got=%h want=1005", outq_a); end
        total++; if (selq_a !== 3'd5) begin bad++; $display("FAIL hold_selq got=%0d want=5", selq_a); end
    endtask

    task automatic test_mask();
        set_ramp();
        select = 3'd7; load = 1'b0;
        #1;
        total++; if (out_b !== 16'h0000) begin bad++; $display("FAIL mask_out got=%h want=0000", out_b); end
        total++; if (out_a !== 16'h1007) begin bad++; $display("FAIL nomask_out got=%h want=1007", out_a); end
        load = 1'b1;
        tick();
        total++; if (outq_b !== 16'h0000) begin bad++; $display("FAIL mask_outq got=%h want=0000", outq_b); end
        total++; if (selq_b !== 3'd7) begin bad++; $display("FAIL mask_selq got=%0d want=7", selq_b); end
`ifdef MUX_8_1_SEL_ERR_EN
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL mask_err_set got=%b want=1", err_b); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL full_err got=%b want=0", err_a); end
`endif
        select = 3'd3;
        tick();
        total++; if (outq_b !== 16'h1003) begin bad++; $display("FAIL mask_outq3 got=%h want=1003", outq_b); end
`ifdef MUX_8_1_SEL_ERR_EN
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL mask_err_clr got=%b want=0", err_b); end
`endif
        load = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] mq_a, mq_b;
        logic [2:0]   ms_a, ms_b;
        logic         me_b;
        reset_n = 1'b0; load = 1'b0;
        tick();
        mq_a = '0; mq_b = '0; ms_a = '0; ms_b = '0; me_b = 1'b0;
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 8; k++) in_w[k] = W'($urandom);
            select  = 3'($urandom_range(0, 7));
            load    = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 7) != 0);
            #1;
            total++; if (out_a !== pick(8'hFF, select)) begin bad++; $display("FAIL rnd_out_a n=%0d got=%h want=%h", n, out_a, pick(8'hFF, select)); end
            total++; if (out_b !== pick(8'h7F, select)) begin bad++; $display("FAIL rnd_out_b n=%0d got=%h want=%h", n, out_b, pick(8'h7F, select)); end
            if (!reset_n) begin
                mq_a = '0; mq_b = '0; ms_a = '0; ms_b = '0; me_b = 1'b0;
            end else if (load) begin
                mq_a = pick(8'hFF, select); ms_a = select;
                mq_b = pick(8'h7F, select); ms_b = select;
                me_b = (select == 3'd7);
            end
            tick();
            total++; if (outq_a !== mq_a) begin bad++; $display("FAIL rnd_outq_a n=%0d got=%h want=%h", n, outq_a, mq_a); end
            total++; if (selq_a !== ms_a) begin bad++; $display("FAIL rnd_selq_a n=%0d got=%0d want=%0d", n, selq_a, ms_a); end
            total++; if (outq_b !== mq_b) begin bad++; $display("FAIL rnd_outq_b n=%0d got=%h want=%h", n, outq_b, mq_b); end
            total++; if (selq_b !== ms_b) begin bad++; $display("FAIL rnd_selq_b n=%0d got=%0d want=%0d", n, selq_b, ms_b); end
`ifdef MUX_8_1_SEL_ERR_EN
            total++; if (err_b !== me_b) begin bad++; $display("FAIL rnd_err_b n=%0d got=%b want=%b", n, err_b, me_b); end
`endif
        end
        reset_n = 1'b1; load = 1'b0;
    endtask

    // Mux used as a register: select = {reset, we, incr}, IN_1 fed back as OUT_Q+1.
    task automatic gr_step(input logic [2:0] s, input logic [W-1:0] data, inout logic [W-1:0] r);
        in_w[0] = outq_a;
        in_w[1] = outq_a + 1'b1;
        in_w[2] = data;
        in_w[3] = data;
        for (int k = 4; k < 8; k++) in_w[k] = '0;
        select = s; load = 1'b1;
        if (s[2])      r = '0;
        else if (s[1]) r = data;
        else if (s[0]) r = r + 16'd1;
        tick();
        total++;
        if (outq_a !== r) begin
            bad++; $display("FAIL genreg sel=%b got=%h want=%h", s, outq_a, r);
        end
    endtask

    task automatic test_generic_register();
        logic [W-1:0] r;
        r = 16'h5555;
        gr_step(3'b010, 16'hFFFA, r);
        for (int i = 0; i < 10; i++) gr_step(3'b001, 16'h0000, r);
        total++; if (outq_a !== 16'h0004) begin bad++; $display("FAIL genreg_wrap got=%h want=0004", outq_a); end
        gr_step(3'b011, 16'h1234, r);
        gr_step(3'b000, 16'hAAAA, r);
        gr_step(3'b110, 16'hBEEF, r);
        gr_step(3'b101, 16'hBEEF, r);
        load = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) in_w[k] = '0;
        test_reset();
        test_sweep();
        test_load_hold();
        test_mask();
        test_random();
        test_generic_register();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_8_1.md
MUX_8_1 -- requirements
Module: mux_8_1

Interface
REQ-001 SHALL provide parameter WORD, default 16, data width of every data input and output.
REQ-002 SHALL provide parameter LANE_MASK, default 8'hFF, where bit k=1 enables input IN_k.
REQ-003 SHALL provide port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1 bit, synchronous active-low reset sampled on rising clk.
REQ-005 SHALL provide port select, input, 3 bits, binary index of the chosen input.
REQ-006 SHALL provide ports IN_0 through IN_7, input, WORD bits each, candidate data words.
REQ-007 SHALL provide port load, input, 1 bit, registered-output capture enable.
REQ-008 SHALL provide port OUT, output, WORD bits, combinational selected word.
REQ-009 SHALL provide port OUT_Q, output, WORD bits, registered copy of OUT.
REQ-010 SHALL provide port sel_q, output, 3 bits, select value captured with OUT_Q.

Function
REQ-011 OUT SHALL equal IN_<select> combinationally, with zero latency, for every enabled lane.
REQ-012 OUT SHALL be all zeros when select addresses a lane whose LANE_MASK bit is 0.
REQ-013 The decode SHALL be full: all 8 select codes are defined, and no latch is inferred.
REQ-014 On a rising clk with reset_n=1 and load=1, OUT_Q SHALL take OUT and sel_q SHALL take select, with one-cycle latency.
REQ-015 On a rising clk with reset_n=1 and load=0, OUT_Q and sel_q SHALL hold their values.
REQ-016 A change on select or IN_k SHALL propagate to OUT in the same cycle and to OUT_Q only after the next loading edge.
REQ-017 Data SHALL pass through unmodified: no arithmetic, no width change, bit k of OUT from bit k of the selected input.

Reset
REQ-018 When reset_n=0 at a rising clk, OUT_Q SHALL become 0 and sel_q SHALL become 3'b000, regardless of load.
REQ-019 Reset SHALL take priority over load.
REQ-020 Reset SHALL have no effect on the combinational OUT.
REQ-021 Until the first reset or load edge, OUT_Q SHALL power up at 0 through an initial value.

Configuration
REQ-022 Macro MUX_8_1_SEL_ERR_EN SHALL add output sel_err, 1 bit, registered.
REQ-023 With MUX_8_1_SEL_ERR_EN defined, a loading edge SHALL set sel_err to 1 when select addresses a masked lane, and to 0 otherwise.
REQ-024 With MUX_8_1_SEL_ERR_EN defined, reset SHALL clear sel_err to 0.
REQ-025 Without MUX_8_1_SEL_ERR_EN, the sel_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 A shared package mux_8_1_pkg SHALL hold the select width constant (3), the lane count (8) and the default LANE_MASK.
REQ-027 The combinational decode SHALL be one sub-module, mux_8_1_sel.
REQ-028 mux_8_1_sel SHALL take select, the eight inputs and LANE_MASK, and produce OUT.
REQ-029 The top level SHALL hold only the output registers and the optional error flag.

Verification
REQ-030 Scenario 1: WORD=16, IN_k=16'h1000+k; sweep select 0..7 -> OUT=16'h1000..16'h1007 in the same cycle.
REQ-031 Scenario 2: select=5, load=1, one edge -> OUT_Q=16'h1005 and sel_q=5; then load=0 and select=2 -> OUT=16'h1002 while OUT_Q stays 16'h1005.
REQ-032 Scenario 3: reset_n=0 with load=1 and select=7 -> OUT_Q=0 and sel_q=0 after the edge, while OUT=16'h1007.
REQ-033 Scenario 4: LANE_MASK=8'h7F, select=7 -> OUT=0; with the macro defined, load -> sel_err=1, then select=3 and load -> sel_err=0.
REQ-034 Scenario 5: generic_register usage with select={reset,we,incr}: 3'b001 returns OUT+1, 3'b010 and 3'b011 return DATA, 3'b1xx returns 0, checked over 10 increments from 16'hFFFA wrapping to 16'h0004.
